// File: rtl/tone_pkg.sv
// Shared types and constants for the tone generator: note LUT, state enum,
// rest/silent codes and the note-to-phase-increment helper.
package tone_pkg;

    localparam logic [3:0] REST_MIN    = 4'd12;  // codes 12..15 are rests
    localparam logic [3:0] NOTE_SILENT = 4'hF;   // outNote value while silent

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } tone_state_t;

    // Octave-7 phase increments for a 100 MHz clock:
    // round(f_oct7 * 2^32 / 100e6); lower octaves are right shifts of these.
    function automatic logic [31:0] lut_oct7(input logic [3:0] note);
        logic [31:0] v;
        case (note)
            4'd0:    v = 32'd89894;   // C7
            4'd1:    v = 32'd95239;   // C#7
            4'd2:    v = 32'd100902;  // D7
            4'd3:    v = 32'd106902;  // D#7
            4'd4:    v = 32'd113259;  // E7
            4'd5:    v = 32'd119994;  // F7
            4'd6:    v = 32'd127129;  // F#7
            4'd7:    v = 32'd134689;  // G7
            4'd8:    v = 32'd142698;  // G#7
            4'd9:    v = 32'd151183;  // A7
            4'd10:   v = 32'd160173;  // A#7
            4'd11:   v = 32'd169697;  // B7
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Phase increment for a note in a given octave (0..7).
    function automatic logic [31:0] note_inc(input logic [3:0] note, input logic [2:0] oct);
        return lut_oct7(note) >> (3'd7 - oct);
    endfunction

endpackage

// File: rtl/tone_pwm.sv
// 8-bit free-running PWM: output is high while the square is high and the
// counter sits below the volume threshold. Registered, so it lags the square by one cycle.
module tone_pwm #(
    parameter int C_VOLUME = 128
) (
    input  logic clk,
    input  logic rstb,
    input  logic i_square,
    output logic o_pwm
);

    logic [7:0] r_pwm_cnt;
    logic       r_pwm;

    // Free-running duty counter, wraps 255 -> 0.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_pwm_cnt <= 8'd0;
        else       r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end

    // Duty compare against the volume, gated by the square.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_pwm <= 1'b0;
        else       r_pwm <= i_square & ({1'b0, r_pwm_cnt} < 9'(C_VOLUME));
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/tone_gen.sv
// Tone generator: note code -> DDS square wave, gated by a note-duration /
// articulation FSM, driven out as 1-bit PWM and reported to the lights.
module tone_gen
    import tone_pkg::*;
#(
    parameter int C_CLK_FRQ         = 100_000_000,
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_NOTE_MS         = 250,
    parameter int C_GAP_MS          = 20,
    parameter int C_VOLUME          = 128,
    // Prescaler period in cycles; derived from the clock, overridable to shorten simulation.
    parameter int C_MS_CYCLES       = C_CLK_FRQ / 1000
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         inValid,
    input  logic [C_UART_DATA_WIDTH-1:0] inCode,
    output logic                         outPWM,
    output logic                         outSquare,
    output logic                         outBusy,
    output logic [3:0]                   outNote
);

    if (C_CLK_FRQ != 100_000_000) begin : g_bad_clk
        $error("tone_gen: frequency LUT only valid for C_CLK_FRQ = 100_000_000");
    end
    if (C_UART_DATA_WIDTH != 8) begin : g_bad_width
        $error("tone_gen: C_UART_DATA_WIDTH must be 8");
    end
    if (C_VOLUME < 0 || C_VOLUME > 255) begin : g_bad_vol
        $error("tone_gen: C_VOLUME must be 0..255");
    end

    tone_state_t r_state, w_state_nxt;
    logic [31:0] r_phase, r_inc, r_presc;
    logic [15:0] r_ms_cnt;
    logic        r_sustain;
    logic [3:0]  r_note;

    logic w_is_rest, w_load, w_rest, w_ms_tick, w_ms_clr, w_square;

    assign w_is_rest = inCode[3:0] >= REST_MIN;
    assign w_load    = inValid & ~w_is_rest;
    assign w_rest    = inValid &  w_is_rest;
    assign w_ms_tick = r_presc == 32'(C_MS_CYCLES - 1);

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: duration/gap expiry, with an incoming code overriding expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_ms_clr    = 1'b0;
        unique case (r_state)
            IDLE: ;
            PLAY: if (w_ms_tick && !r_sustain && r_ms_cnt == 16'(C_NOTE_MS - 1)) begin
                w_state_nxt = GAP;
                w_ms_clr    = 1'b1;
            end
            GAP: if (w_ms_tick && r_ms_cnt == 16'(C_GAP_MS - 1)) begin
                w_state_nxt = IDLE;
                w_ms_clr    = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_load)      w_state_nxt = PLAY;
        else if (w_rest) w_state_nxt = IDLE;
    end

    // Datapath: note load, phase accumulator, ms prescaler and ms counter.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_phase   <= 32'd0;
            r_inc     <= 32'd0;
            r_presc   <= 32'd0;
            r_ms_cnt  <= 16'd0;
            r_sustain <= 1'b0;
            r_note    <= NOTE_SILENT;
        end else if (w_load) begin
            r_phase   <= 32'd0;
            r_inc     <= note_inc(inCode[3:0], inCode[6:4]);
            r_presc   <= 32'd0;
            r_ms_cnt  <= 16'd0;
            r_sustain <= inCode[7];
            r_note    <= inCode[3:0];
        end else begin
            r_presc <= w_ms_tick ? 32'd0 : r_presc + 32'd1;
            if (r_state == PLAY) r_phase <= r_phase + r_inc;
            if (w_ms_clr)
                r_ms_cnt <= 16'd0;
            else if (w_ms_tick && r_state != IDLE && r_ms_cnt != 16'hFFFF)
                r_ms_cnt <= r_ms_cnt + 16'd1;  // saturates while sustained
        end
    end

    assign w_square  = (r_state == PLAY) & r_phase[31];
    assign outSquare = w_square;
    assign outBusy   = r_state != IDLE;
    assign outNote   = (r_state == PLAY) ? r_note : NOTE_SILENT;

    tone_pwm #(.C_VOLUME(C_VOLUME)) u_pwm (
        .clk      (clk),
        .rstb     (rstb),
        .i_square (w_square),
        .o_pwm    (outPWM)
    );

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: two instances share stimulus (volume 128 and 64).
// Prescaler shortened to 100 cycles/ms; note = 2 ms, gap = 1 ms.
module tb_tone_gen;

    logic       clk = 1'b0, rstb = 1'b0, inValid = 1'b0;
    logic [7:0] inCode = 8'h00;
    logic       outPWM, outSquare, outBusy;
    logic [3:0] outNote;
    logic       pwm64, sq64, busy64;
    logic [3:0] note64;

    int n_cmp = 0, n_err = 0;

    tone_gen #(.C_NOTE_MS(2), .C_GAP_MS(1), .C_VOLUME(128), .C_MS_CYCLES(100)) dut (
        .clk(clk), .rstb(rstb), .inValid(inValid), .inCode(inCode),
        .outPWM(outPWM), .outSquare(outSquare), .outBusy(outBusy), .outNote(outNote));

    tone_gen #(.C_NOTE_MS(2), .C_GAP_MS(1), .C_VOLUME(64), .C_MS_CYCLES(100)) dut_v64 (
        .clk(clk), .rstb(rstb), .inValid(inValid), .inCode(inCode),
        .outPWM(pwm64), .outSquare(sq64), .outBusy(busy64), .outNote(note64));

    always #5 clk = ~clk;

    // Reference duty counter: free-running from reset release.
    logic [7:0] m_cnt;
    always @(posedge clk or negedge rstb) begin
        if (!rstb) m_cnt <= 8'd0;
        else       m_cnt <= m_cnt + 8'd1;
    end

    // Cycle-exact PWM tracking of both instances, plus high-time counters.
    logic       chk_en = 1'b0, prev_ok = 1'b0, meas = 1'b0;
    logic       sq_last = 1'b0, sq64_last = 1'b0;
    logic [7:0] m_last = 8'd0;
    int pwm_bad = 0, s64 = 0, p64 = 0;
    always @(negedge clk) begin
        if (chk_en && prev_ok)
            pwm_bad <= pwm_bad + int'(outPWM !== (sq_last & (m_last < 8'd128)))
                               + int'(pwm64  !== (sq64_last & (m_last < 8'd64)));
        if (meas) begin
            s64 <= s64 + int'(sq64);
            p64 <= p64 + int'(pwm64);
        end
        sq_last   <= outSquare;
        sq64_last <= sq64;
        m_last    <= m_cnt;
        prev_ok   <= chk_en & rstb;
    end

    // One-cycle code strobe; called and returns at a negedge.
    task automatic strobe(input logic [7:0] c);
        inValid = 1'b1;
        inCode  = c;
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic wait_note(input logic [3:0] want, input int limit, output int n);
        n = 0;
        while (outNote !== want && n < limit) begin @(negedge clk); n++; end
    endtask

    task automatic wait_busy(input logic want, input int limit, output int n);
        n = 0;
        while (outBusy !== want && n < limit) begin @(negedge clk); n++; end
    endtask

    task automatic wait_sq(input logic want, input int limit, output int n);
        n = 0;
        while (outSquare !== want && n < limit) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (outBusy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", outBusy); end
        n_cmp++; if (outNote !== 4'hF)   begin n_err++; $display("FAIL reset_note: got %h want f", outNote); end
        n_cmp++; if (outSquare !== 1'b0) begin n_err++; $display("FAIL reset_square: got %b want 0", outSquare); end
        n_cmp++; if (outPWM !== 1'b0)    begin n_err++; $display("FAIL reset_pwm: got %b want 0", outPWM); end
        rstb   = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_duration;
        int n;
        strobe(8'h49);
        n_cmp++; if (outBusy !== 1'b1) begin n_err++; $display("FAIL dur_busy_start: got %b want 1", outBusy); end
        n_cmp++; if (outNote !== 4'd9) begin n_err++; $display("FAIL dur_note: got %0d want 9", outNote); end
        wait_note(4'hF, 1000, n);
        n_cmp++; if (n != 200) begin n_err++; $display("FAIL dur_play_len: got %0d want 200", n); end
        n_cmp++; if (outBusy !== 1'b1) begin n_err++; $display("FAIL dur_gap_busy: got %b want 1", outBusy); end
        wait_busy(1'b0, 1000, n);
        n_cmp++; if (n != 100) begin n_err++; $display("FAIL dur_gap_len: got %0d want 100", n); end
    endtask

    task automatic test_sustain_rest;
        strobe(8'hC9);
        repeat (500) @(negedge clk);
        n_cmp++; if (outBusy !== 1'b1) begin n_err++; $display("FAIL sus_busy: got %b want 1", outBusy); end
        n_cmp++; if (outNote !== 4'd9) begin n_err++; $display("FAIL sus_note: got %0d want 9", outNote); end
        strobe(8'h0C);
        n_cmp++; if (outBusy !== 1'b0) begin n_err++; $display("FAIL rest_busy: got %b want 0", outBusy); end
        n_cmp++; if (outNote !== 4'hF) begin n_err++; $display("FAIL rest_note: got %h want f", outNote); end
    endtask

    task automatic test_retrigger;
        int n;
        strobe(8'h40);
        repeat (49) @(negedge clk);
        strobe(8'h47);
        n_cmp++; if (outNote !== 4'd7) begin n_err++; $display("FAIL retrig_note: got %0d want 7", outNote); end
        wait_note(4'hF, 1000, n);
        n_cmp++; if (n != 200) begin n_err++; $display("FAIL retrig_len: got %0d want 200", n); end
        repeat (10) @(negedge clk);
        strobe(8'h45);
        n_cmp++; if (outNote !== 4'd5) begin n_err++; $display("FAIL gap_retrig_note: got %0d want 5", outNote); end
        wait_note(4'hF, 1000, n);
        n_cmp++; if (n != 200) begin n_err++; $display("FAIL gap_retrig_len: got %0d want 200", n); end
        wait_busy(1'b0, 1000, n);
    endtask

    task automatic test_back_to_back;
        int n;
        strobe(8'h42);
        repeat (199) @(negedge clk);
        n_cmp++; if (outNote !== 4'd2) begin n_err++; $display("FAIL b2b_pre_note: got %0d want 2", outNote); end
        strobe(8'h45);  // lands on the expiry edge
        n_cmp++; if (outNote !== 4'd5) begin n_err++; $display("FAIL b2b_note: got %0d want 5", outNote); end
        n_cmp++; if (outBusy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", outBusy); end
        wait_note(4'hF, 1000, n);
        n_cmp++; if (n != 200) begin n_err++; $display("FAIL b2b_len: got %0d want 200", n); end
        wait_busy(1'b0, 1000, n);
    endtask

    // Sustained B7: inc 169697, rises after 12655 cycles, falls (wraps) after 25310.
    task automatic test_square_pwm;
        int n1, n2, d;
        strobe(8'hFB);
        meas = 1'b1;
        wait_sq(1'b1, 20000, n1);
        n_cmp++; if (n1 != 12655) begin n_err++; $display("FAIL sq_rise: got %0d want 12655", n1); end
        wait_sq(1'b0, 20000, n2);
        n_cmp++; if (n1 + n2 != 25310) begin n_err++; $display("FAIL sq_fall: got %0d want 25310", n1 + n2); end
        repeat (2) @(negedge clk);
        meas = 1'b0;
        @(negedge clk);
        n_cmp++; if (s64 != 12655) begin n_err++; $display("FAIL sq_high_time: got %0d want 12655", s64); end
        d = 4 * p64 - s64;
        if (d < 0) d = -d;
        n_cmp++; if (d > s64 / 64) begin n_err++; $display("FAIL pwm_ratio64: got %0d/%0d want 1/4", p64, s64); end
        n_cmp++; if (pwm_bad != 0) begin n_err++; $display("FAIL pwm_track: got %0d bad cycles want 0", pwm_bad); end
    endtask

    // Sustained B6: inc 84848, first rise after 25310 cycles.
    task automatic test_octave;
        int n;
        strobe(8'hEB);
        wait_sq(1'b1, 30000, n);
        n_cmp++; if (n != 25310) begin n_err++; $display("FAIL oct6_rise: got %0d want 25310", n); end
    endtask

    task automatic test_async_reset;
        n_cmp++; if (outNote !== 4'd11) begin n_err++; $display("FAIL pre_areset_note: got %0d want 11", outNote); end
        chk_en = 1'b0;
        #2 rstb = 1'b0;
        #1;
        n_cmp++; if (outSquare !== 1'b0) begin n_err++; $display("FAIL areset_square: got %b want 0", outSquare); end
        n_cmp++; if (outBusy !== 1'b0)   begin n_err++; $display("FAIL areset_busy: got %b want 0", outBusy); end
        n_cmp++; if (outNote !== 4'hF)   begin n_err++; $display("FAIL areset_note: got %h want f", outNote); end
        n_cmp++; if (outPWM !== 1'b0 || pwm64 !== 1'b0) begin n_err++; $display("FAIL areset_pwm: got %b%b want 00", outPWM, pwm64); end
    endtask

    initial begin
        test_reset();
        test_duration();
        test_sustain_rest();
        test_retrigger();
        test_back_to_back();
        test_square_pwm();
        test_octave();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
